// File: rtl/down_timer.sv
// down_timer
//   Loadable down-counting timer. A load starts the count from load_val. The count
//   then decrements on every clock where enable is high, and done pulses for one
//   cycle at expiry. In one-shot mode the timer stops at 0. In periodic mode it
//   reloads the start value and keeps running.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous reset, active-low
//   load      load load_val and start (wins over stop and enable)
//   load_val  start / reload value, sampled with load
//   enable    decrement qualifier; low pauses the count
//   periodic  auto-reload mode, captured with load
//   stop      abort to IDLE, count frozen
//   count     current count (registered)
//   busy      high while RUN or PAUSE
//   done      one-cycle expiry pulse (registered)
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | not counting; count holds, enable ignored
// S_RUN   | counting; decrements on each enabled edge
// S_PAUSE | started but enable was low; count holds until enable returns

module down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             periodic,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  logic [1:0]       state, state_nx;
  logic [WIDTH-1:0] count_nx;
  logic [WIDTH-1:0] reload, reload_nx;
  logic             mode, mode_nx;
  logic             done_nx;

  always_comb begin
    state_nx  = state;
    count_nx  = count;
    reload_nx = reload;
    mode_nx   = mode;
    done_nx   = 1'b0;

    if (load) begin
      count_nx  = load_val;
      reload_nx = load_val;
      mode_nx   = periodic;
      // A zero start value has nothing to count, so it parks in IDLE without a done.
      if (load_val == '0)
        state_nx = S_IDLE;
      else if (enable)
        state_nx = S_RUN;
      else
        state_nx = S_PAUSE;
    end else if (stop) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_RUN, S_PAUSE: begin
          if (!enable) begin
            state_nx = S_PAUSE;
          end else if (count == '0) begin
            // Unreachable in normal operation; never decrement through zero.
            state_nx = S_IDLE;
          end else if (count == WIDTH'(1)) begin
            done_nx = 1'b1;
            if (mode) begin
              count_nx = reload;
              state_nx = S_RUN;
            end else begin
              count_nx = '0;
              state_nx = S_IDLE;
            end
          end else begin
            count_nx = count - WIDTH'(1);
            state_nx = S_RUN;
          end
        end
        S_IDLE:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      count  <= '0;
      reload <= '0;
      mode   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      count  <= count_nx;
      reload <= reload_nx;
      mode   <= mode_nx;
      done   <= done_nx;
    end
  end

  assign busy = (state != S_IDLE);

endmodule
